random_history: RTL and testbench

Downstream consumer of the lab1 random generator. It records each final random value when a roll ends into a circular history buffer and drives the 4-bit value shown on the display. While a roll is running it shows the live value; otherwise the user steps through past results with the prev/next keys. Its outputs feed the seven-segment decoder and the LED index indicator.

---
 rtl/random_history.sv | 188 ++++++++++++++++++
 tb/tb_random_history.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_history.sv
// ---------------------------------------------------------------------------
// random_history
//   Keeps the final value of each random roll in a circular history buffer
//   and selects the value shown on the display.
//   While a roll is running the live generator value is shown. Otherwise the
//   user steps through past results with the prev/next keys.
//
// Ports
//   i_clk      rising-edge system clock
//   i_rst_n    asynchronous active-low reset; clears history and outputs
//   i_value    current generator output
//   i_rolling  level, high while the generator rolls
//   i_commit   one-cycle pulse, i_value is the final result of the roll
//   i_prev     one-cycle pulse, step to an older entry
//   i_next     one-cycle pulse, step to a newer entry
//   o_display  registered value to show
//   o_offset   browse offset, 0 = newest entry
//   o_count    number of valid entries, 0..DEPTH
//   o_live     high while showing the live value
// ---------------------------------------------------------------------------
module random_history #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_rolling,
  input  logic              i_commit,
  input  logic              i_prev,
  input  logic              i_next,
  output logic [DATA_W-1:0] o_display,
  output logic [AW-1:0]     o_offset,
  output logic [AW:0]       o_count,
  output logic              o_live
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_LIVE   = 2'd1,
    S_BROWSE = 2'd2
  } state_e;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  state_e              state_q,   state_d;
  logic [AW-1:0]       wr_ptr_q,  wr_ptr_d;
  logic [AW:0]         count_q,   count_d;
  logic [AW-1:0]       offset_q,  offset_d;
  logic [DATA_W-1:0]   display_q, display_d;
  logic                live_q,    live_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                wr_en;
  logic [AW-1:0]       rd_addr;

  // Next-state, pointer, counter, offset and display selection
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    offset_d  = offset_q;
    wr_en     = 1'b0;
    rd_addr   = '0;
    display_d = '0;
    live_d    = 1'b0;

    case (state_q)
      S_EMPTY: begin
        if (i_rolling) begin
          state_d = S_LIVE;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_LIVE: begin
        // A commit wins over the rolling level in the same cycle.
        if (i_commit) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end else begin
            count_d = count_q;
          end
          offset_d = '0;
          state_d  = S_BROWSE;
        end else if (!i_rolling) begin
          // Aborted roll: fall back to history, or empty if there is none.
          offset_d = '0;
          if (count_q != '0) begin
            state_d = S_BROWSE;
          end else begin
            state_d = S_EMPTY;
          end
        end else begin
          state_d = S_LIVE;
        end
      end
      S_BROWSE: begin
        if (i_rolling) begin
          state_d = S_LIVE;
        end else if (i_prev && !i_next) begin
          // Oldest valid entry sits at offset count-1.
          if (({1'b0, offset_q} + CNT_ONE) < count_q) begin
            offset_d = offset_q + PTR_ONE;
          end else begin
            offset_d = offset_q;
          end
        end else if (i_next && !i_prev) begin
          if (offset_q != '0) begin
            offset_d = offset_q - PTR_ONE;
          end else begin
            offset_d = offset_q;
          end
        end else begin
          offset_d = offset_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    // Newest entry lives one slot behind the write pointer; wraps in AW bits.
    rd_addr = wr_ptr_q - PTR_ONE - offset_d;

    case (state_d)
      S_LIVE: begin
        display_d = i_value;
      end
      S_BROWSE: begin
        // The slot being written this cycle is not readable yet; bypass it.
        if (wr_en) begin
          display_d = i_value;
        end else begin
          display_d = mem_q[rd_addr];
        end
      end
      S_EMPTY: begin
        display_d = '0;
      end
      default: begin
        display_d = '0;
      end
    endcase

    live_d = (state_d == S_LIVE);
  end

  // Control and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_EMPTY;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      offset_q  <= '0;
      display_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      offset_q  <= offset_d;
      display_q <= display_d;
      live_q    <= live_d;
    end
  end

  // History storage, cleared on reset so stale rolls never reappear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= i_value;
    end
  end

  assign o_display = display_q;
  assign o_offset  = offset_q;
  assign o_count   = count_q;
  assign o_live    = live_q;

endmodule

// File: tb/tb_random_history.sv
// ---------------------------------------------------------------------------
// tb_random_history
//   Drives random_history with directed sequences and randomized traffic and
//   compares every cycle against a queue-based reference of the history.
// ---------------------------------------------------------------------------
module tb_random_history;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 4;
  localparam int AW     = $clog2(DEPTH);

  localparam int M_EMPTY  = 0;
  localparam int M_LIVE   = 1;
  localparam int M_BROWSE = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] value;
  logic              rolling, commit, prev, next;
  logic [DATA_W-1:0] o_display;
  logic [AW-1:0]     o_offset;
  logic [AW:0]       o_count;
  logic              o_live;

  int total = 0;
  int bad   = 0;

  // reference model: newest result at index 0
  logic [DATA_W-1:0] hist[$];
  int                m_mode = M_EMPTY;
  int                m_off  = 0;
  int                m_disp = 0;

  random_history #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_value   (value),
    .i_rolling (rolling),
    .i_commit  (commit),
    .i_prev    (prev),
    .i_next    (next),
    .o_display (o_display),
    .o_offset  (o_offset),
    .o_count   (o_count),
    .o_live    (o_live)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_mode = M_EMPTY;
    m_off  = 0;
    m_disp = 0;
  endtask

  // one clock of the behavioural rules, using the inputs present at the edge
  task automatic model_clock();
    case (m_mode)
      M_EMPTY: begin
        if (rolling) begin
          m_mode = M_LIVE;
          m_disp = value;
        end else begin
          m_disp = 0;
        end
      end
      M_LIVE: begin
        if (commit) begin
          hist.push_front(value);
          if (hist.size() > DEPTH) void'(hist.pop_back());
          m_off  = 0;
          m_mode = M_BROWSE;
          m_disp = value;
        end else if (!rolling) begin
          m_off = 0;
          if (hist.size() > 0) begin
            m_mode = M_BROWSE;
            m_disp = hist[0];
          end else begin
            m_mode = M_EMPTY;
            m_disp = 0;
          end
        end else begin
          m_disp = value;
        end
      end
      default: begin
        if (rolling) begin
          m_mode = M_LIVE;
          m_disp = value;
        end else begin
          if (prev && !next && (m_off + 1 < hist.size())) m_off++;
          if (next && !prev && (m_off > 0)) m_off--;
          m_disp = hist[m_off];
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".display"}, 32'(o_display), 32'(m_disp));
    chk({tag, ".offset"},  32'(o_offset),  32'(m_off));
    chk({tag, ".count"},   32'(o_count),   32'(hist.size()));
    chk({tag, ".live"},    32'(o_live),    32'(m_mode == M_LIVE));
  endtask

  // apply one cycle of inputs, clock, then compare just after the edge
  task automatic step(input bit r, input bit c, input bit p, input bit n,
                      input logic [DATA_W-1:0] v, input string tag);
    rolling = r;
    commit  = c;
    prev    = p;
    next    = n;
    value   = v;
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  // reset asserted between clock edges; outputs must clear without a clock
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    value   = 4'h0;
    rolling = 1'b0;
    commit  = 1'b0;
    prev    = 1'b0;
    next    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    #2;
    rst_n = 1'b1;

    // keys ignored while empty
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "empty_prev");
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "empty_next");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, "empty_both");
    chk("empty_count_const", 32'(o_count), 32'd0);

    // two rolls, browse with saturation at both ends
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, "roll1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h5, "commit5");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h7, "roll2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, "commitA");
    chk("two_count_const", 32'(o_count), 32'd2);
    chk("two_disp_const", 32'(o_display), 32'hA);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "prev1");
    chk("prev1_disp_const", 32'(o_display), 32'h5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "prev_sat");
    chk("prev_sat_off_const", 32'(o_offset), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "next1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "next_sat");
    chk("next_sat_disp_const", 32'(o_display), 32'hA);

    // ten commits into eight slots: oldest two overwritten
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'(k + 5), "fill_roll");
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'(k), "fill_commit");
    end
    chk("full_count_const", 32'(o_count), 32'd8);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "full_prev");
    chk("oldest_disp_const", 32'(o_display), 32'h3);
    chk("oldest_off_const", 32'(o_offset), 32'd7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "full_prev_sat");
    chk("full_sat_disp_const", 32'(o_display), 32'h3);

    // live tracking from empty, then abort back to empty
    async_reset("rst_mid_browse_a");
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, k[0], 1'b0, 4'(k), "live_track");
      chk("live_lag_const", 32'(o_display), 32'(k));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h9, "abort_empty");
    chk("abort_live_const", 32'(o_live), 32'd0);

    // commit with a coincident prev; then prev+next together
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, "cp_roll");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'hC, "cp_commit");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h2, "cp_roll2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'hD, "cp_commit2");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "cp_prev");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, "both_keys");
    chk("both_off_const", 32'(o_offset), 32'd1);

    // reset mid-browse, then the next commit starts a fresh history
    async_reset("rst_mid_browse_b");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h4, "post_rst_roll");
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'hE, "post_rst_commit");
    chk("post_rst_count_const", 32'(o_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "post_rst_prev");
    chk("post_rst_disp_const", 32'(o_display), 32'hE);

    // randomized traffic
    rolling = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      bit r;
      r = rolling;
      if ($urandom_range(0, 5) == 0) r = ~r;
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rnd_reset");
      end else begin
        step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
